// File: rtl/br_upd_pkg.sv
// Shared types for the branch-update path between the BRUs and branch_unit.
package br_upd_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } br_upd_t;

  localparam int BR_UPD_W = 65;

  function automatic br_upd_t mk_upd(input logic [31:0] pc, input logic [31:0] target,
                                     input logic taken);
    br_upd_t u;
    u.pc     = pc;
    u.target = target;
    u.taken  = taken;
    return u;
  endfunction

endpackage

// File: rtl/br_upd_fifo.sv
// In-order update queue: DEPTH entries, up to two writes and one read per cycle, 1-cycle write-to-read.
// No internal backpressure; the caller must never write past DEPTH (it gates on count).
module br_upd_fifo
  import br_upd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    wr_cnt,
  input  br_upd_t       wr_dat0,
  input  br_upd_t       wr_dat1,
  input  logic          rd_en,
  output br_upd_t       rd_dat,
  output logic [AW:0]   count
);

  br_upd_t       mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr_p1;
  logic [AW:0]   count_nxt;

  assign wptr_p1 = wptr + AW'(1);
  assign rd_dat  = mem[rptr];

  always_comb begin
    count_nxt = count + {{(AW-1){1'b0}}, wr_cnt} - {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_cnt);
      rptr  <= rptr + AW'(rd_en);
      count <= count_nxt;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wr_cnt != 2'd0) mem[wptr] <= wr_dat0;
      if (wr_cnt == 2'd2) mem[wptr_p1] <= wr_dat1;
    end
  end

endmodule

// File: rtl/br_update_arbiter.sv
// Serialises two-lane branch resolutions onto one branch_unit update port (optional stats: BR_UPD_STATS_EN).
// Latency 1 cycle via bypass on an empty queue; one update emitted per cycle at most.
// o_ready low drops the whole input cycle; branch_unit never backpressures.
module br_update_arbiter
  import br_upd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd0_valid,
  input  logic             i_upd0_taken,
  input  logic [31:0]      i_upd0_pc,
  input  logic [31:0]      i_upd0_target,
  input  logic             i_upd1_valid,
  input  logic             i_upd1_taken,
  input  logic [31:0]      i_upd1_pc,
  input  logic [31:0]      i_upd1_target,
  input  logic             i_kill1,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_br_update_en,
  output logic             o_br_update_valid,
  output logic             o_br_update_taken,
  output logic [31:0]      o_br_update_pc,
  output logic [31:0]      o_br_update_target
`ifdef BR_UPD_STATS_EN
  ,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_full_cyc_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);

  br_upd_t     lane0;
  br_upd_t     lane1;
  br_upd_t     head;
  br_upd_t     out_dat;
  br_upd_t     wr_dat0;
  br_upd_t     wr_dat1;
  logic [1:0]  wr_cnt;
  logic [AW:0] count;
  logic        acc0;
  logic        acc1;
  logic        drop;
  logic        take0;
  logic        take1;
  logic        rd_en;
  logic        out_en;

  assign lane0 = mk_upd(i_upd0_pc, i_upd0_target, i_upd0_taken);
  assign lane1 = mk_upd(i_upd1_pc, i_upd1_target, i_upd1_taken);

  assign o_ready = (count <= RDY_MAX);
  assign acc0    = i_upd0_valid;
  assign acc1    = i_upd1_valid & ~i_kill1;
  assign drop    = ~i_flush & ~o_ready & (acc0 | acc1);
  assign take0   = acc0 & ~drop & ~i_flush;
  assign take1   = acc1 & ~drop & ~i_flush;

  // Oldest first: queue head, then lane 0, then lane 1; the rest goes to the tail in order.
  always_comb begin
    out_en  = 1'b0;
    out_dat = head;
    rd_en   = 1'b0;
    wr_cnt  = 2'd0;
    wr_dat0 = lane0;
    wr_dat1 = lane1;
    if (i_flush) begin
      out_en = 1'b0;
    end else if (count != '0) begin
      out_en = 1'b1;
      rd_en  = 1'b1;
      wr_cnt = {1'b0, take0} + {1'b0, take1};
      if (!take0) wr_dat0 = lane1;
    end else if (take0) begin
      out_en  = 1'b1;
      out_dat = lane0;
      wr_cnt  = {1'b0, take1};
      wr_dat0 = lane1;
    end else if (take1) begin
      out_en  = 1'b1;
      out_dat = lane1;
    end
  end

  br_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .flush   (i_flush),
    .wr_cnt  (wr_cnt),
    .wr_dat0 (wr_dat0),
    .wr_dat1 (wr_dat1),
    .rd_en   (rd_en),
    .rd_dat  (head),
    .count   (count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_update_en     <= 1'b0;
      o_br_update_taken  <= 1'b0;
      o_br_update_pc     <= '0;
      o_br_update_target <= '0;
    end else begin
      o_br_update_en <= out_en;
      if (out_en) begin
        o_br_update_taken  <= out_dat.taken;
        o_br_update_pc     <= out_dat.pc;
        o_br_update_target <= out_dat.target;
      end
    end
  end

  assign o_br_update_valid = o_br_update_en;

`ifdef BR_UPD_STATS_EN
  logic [CNT_W:0] drop_sum;
  logic [CNT_W:0] full_sum;

  assign drop_sum = {1'b0, o_drop_cnt} +
                    (drop ? ((CNT_W+1)'(acc0) + (CNT_W+1)'(acc1)) : '0);
  assign full_sum = {1'b0, o_full_cyc_cnt} + (CNT_W+1)'(~o_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt     <= '0;
      o_full_cyc_cnt <= '0;
    end else begin
      o_drop_cnt     <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      o_full_cyc_cnt <= full_sum[CNT_W] ? '1 : full_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_br_update_arbiter.sv
// Directed bench for br_update_arbiter: expected updates queued at issue, popped by a negedge monitor.
module tb_br_update_arbiter;
  import br_upd_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_upd0_valid, i_upd0_taken;
  logic [31:0] i_upd0_pc, i_upd0_target;
  logic        i_upd1_valid, i_upd1_taken;
  logic [31:0] i_upd1_pc, i_upd1_target;
  logic        i_kill1, i_flush;
  logic        o_ready, o_br_update_en, o_br_update_valid, o_br_update_taken;
  logic [31:0] o_br_update_pc, o_br_update_target;
`ifdef BR_UPD_STATS_EN
  logic [15:0] o_drop_cnt, o_full_cyc_cnt;
  logic [15:0] drop_before;
`endif

  int checks = 0;
  int errors = 0;
  br_upd_t exp_q[$];

  br_update_arbiter #(.DEPTH(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_upd0_valid(i_upd0_valid), .i_upd0_taken(i_upd0_taken),
    .i_upd0_pc(i_upd0_pc), .i_upd0_target(i_upd0_target),
    .i_upd1_valid(i_upd1_valid), .i_upd1_taken(i_upd1_taken),
    .i_upd1_pc(i_upd1_pc), .i_upd1_target(i_upd1_target),
    .i_kill1(i_kill1), .i_flush(i_flush), .o_ready(o_ready),
    .o_br_update_en(o_br_update_en), .o_br_update_valid(o_br_update_valid),
    .o_br_update_taken(o_br_update_taken), .o_br_update_pc(o_br_update_pc),
    .o_br_update_target(o_br_update_target)
`ifdef BR_UPD_STATS_EN
    , .o_drop_cnt(o_drop_cnt), .o_full_cyc_cnt(o_full_cyc_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  // Monitor: every emitted update must match the oldest expected one.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      checks++;
      if (o_br_update_valid !== o_br_update_en) begin
        errors++;
        $display("FAIL valid_eq_en: valid=%0b en=%0b", o_br_update_valid, o_br_update_en);
      end
      if (o_br_update_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got pc=%h, expected none", o_br_update_pc);
        end else begin
          br_upd_t e;
          e = exp_q.pop_front();
          if (o_br_update_pc !== e.pc || o_br_update_target !== e.target ||
              o_br_update_taken !== e.taken) begin
            errors++;
            $display("FAIL update_data: got pc=%h tgt=%h tk=%0b, expected pc=%h tgt=%h tk=%0b",
                     o_br_update_pc, o_br_update_target, o_br_update_taken,
                     e.pc, e.target, e.taken);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    exp_q.push_back(mk_upd(pc, tgt, tk));
  endtask

  task automatic clear_inputs();
    i_upd0_valid = 0; i_upd0_taken = 0; i_upd0_pc = 0; i_upd0_target = 0;
    i_upd1_valid = 0; i_upd1_taken = 0; i_upd1_pc = 0; i_upd1_target = 0;
    i_kill1 = 0; i_flush = 0;
  endtask

  // Apply one input cycle, then return 1 time unit after the capturing edge.
  task automatic step(input logic v0, input logic [31:0] p0, input logic [31:0] t0,
                      input logic k0, input logic v1, input logic [31:0] p1,
                      input logic [31:0] t1, input logic k1, input logic kill,
                      input logic flush);
    i_upd0_valid = v0; i_upd0_pc = p0; i_upd0_target = t0; i_upd0_taken = k0;
    i_upd1_valid = v1; i_upd1_pc = p1; i_upd1_target = t1; i_upd1_taken = k1;
    i_kill1 = kill; i_flush = flush;
    @(posedge i_clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dual(input logic [31:0] pa, input logic [31:0] pb);
    step(1, pa, pa + 32'h1000, 1, 1, pb, pb + 32'h1000, 0, 0, 0);
  endtask

  initial begin
    clear_inputs();
    i_rst_n = 0;
    #22;
    chk("rst_en_low", {31'b0, o_br_update_en}, 0);
    chk("rst_ready_low", {31'b0, o_ready}, 1);
    chk("rst_pc_low", o_br_update_pc, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    idle();
    chk("rst_en", {31'b0, o_br_update_en}, 0);
    chk("rst_ready", {31'b0, o_ready}, 1);
    chk("rst_target", o_br_update_target, 0);
    chk("rst_taken", {31'b0, o_br_update_taken}, 0);

    // Single lane-0 update: bypass, one cycle later, one cycle wide.
    expect_upd(32'h100, 32'h200, 1);
    step(1, 32'h100, 32'h200, 1, 0, 0, 0, 0, 0, 0);
    chk("single_en_n1", {31'b0, o_br_update_en}, 1);
    idle();
    chk("single_en_n2", {31'b0, o_br_update_en}, 0);

    // Dual: lane 0 then lane 1.
    expect_upd(32'h100, 32'h300, 0);
    expect_upd(32'h104, 32'h400, 1);
    step(1, 32'h100, 32'h300, 0, 1, 32'h104, 32'h400, 1, 0, 0);
    chk("dual_en_n1", {31'b0, o_br_update_en}, 1);
    idle();
    chk("dual_en_n2", {31'b0, o_br_update_en}, 1);
    idle();
    chk("dual_en_n3", {31'b0, o_br_update_en}, 0);

    // Fill: counts 1,2,3 after three duals; the fourth dual is dropped while o_ready=0.
    for (int i = 0; i < 6; i++) expect_upd(32'h100 + 32'(4*i), 32'h1100 + 32'(4*i), (i % 2) == 0);
    dual(32'h100, 32'h104);
    chk("fill_ready_c1", {31'b0, o_ready}, 1);
    dual(32'h108, 32'h10C);
    chk("fill_ready_c2", {31'b0, o_ready}, 1);
    dual(32'h110, 32'h114);
    chk("fill_ready_c3", {31'b0, o_ready}, 0);
    dual(32'h118, 32'h11C);
    chk("fill_ready_after_drop", {31'b0, o_ready}, 1);
    idle();
    chk("fill_drain1_en", {31'b0, o_br_update_en}, 1);
    idle();
    chk("fill_drain2_en", {31'b0, o_br_update_en}, 1);
    idle();
    chk("fill_drained_en", {31'b0, o_br_update_en}, 0);
    chk("fill_drained_q", exp_q.size(), 0);

    // Kill: lane 1 is wrong-path, only lane 0 emitted, nothing queued.
    expect_upd(32'h500, 32'h600, 1);
    step(1, 32'h500, 32'h600, 1, 1, 32'h504, 32'h700, 0, 1, 0);
    chk("kill_en_n1", {31'b0, o_br_update_en}, 1);
    idle();
    chk("kill_en_n2", {31'b0, o_br_update_en}, 0);
    chk("kill_ready", {31'b0, o_ready}, 1);

    // Flush with three entries queued (two when stats drop one cycle first).
    expect_upd(32'h200, 32'h1200, 1);
    expect_upd(32'h204, 32'h1204, 0);
    expect_upd(32'h208, 32'h1208, 1);
    dual(32'h200, 32'h204);
    dual(32'h208, 32'h20C);
    dual(32'h210, 32'h214);
    chk("flush_pre_ready", {31'b0, o_ready}, 0);
`ifdef BR_UPD_STATS_EN
    drop_before = o_drop_cnt;
    expect_upd(32'h20C, 32'h120C, 0);
    dual(32'h218, 32'h21C);
    chk("stats_drop_plus2", {16'b0, o_drop_cnt}, {16'b0, drop_before + 16'd2});
`endif
    step(1, 32'h900, 32'h990, 1, 0, 0, 0, 0, 0, 1);
    chk("flush_en", {31'b0, o_br_update_en}, 0);
    chk("flush_ready", {31'b0, o_ready}, 1);
    idle();
    chk("flush_en_n2", {31'b0, o_br_update_en}, 0);
    chk("flush_q", exp_q.size(), 0);

    // Async reset mid-operation: queued lane-1 update must not survive.
    expect_upd(32'h300, 32'h1300, 1);
    dual(32'h300, 32'h304);
    @(negedge i_clk); #1;
    i_rst_n = 0;
    #1;
    chk("arst_en_now", {31'b0, o_br_update_en}, 0);
    chk("arst_pc_now", o_br_update_pc, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    idle();
    chk("arst_en_after", {31'b0, o_br_update_en}, 0);
    chk("arst_ready_after", {31'b0, o_ready}, 1);
    idle();
    chk("arst_en_after2", {31'b0, o_br_update_en}, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
